unsigned_16by8_seq_div: RTL and testbench

Sequential unsigned restoring divider. It is the inverse of the team's unsigned 8x8 multipliers: it recovers the quotient and remainder from a 16-bit product-width dividend and an 8-bit divisor. The bench uses it to check that z / y reproduces x for exact-multiplier outputs and to measure reconstruction error on approximate ones. The datapath produces one quotient bit per cycle, with valid/ready handshakes on both the input and output sides.

---
 rtl/unsigned_16by8_seq_div.sv | 116 +++++++++++
 tb/tb_unsigned_16by8_seq_div.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/unsigned_16by8_seq_div.sv
// Sequential unsigned restoring divider: W_Z-bit dividend / W_Y-bit divisor -> quotient, remainder.
// Latency: W_Z edges from accept to out_valid (1 edge for divide-by-zero); one op in flight.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
module unsigned_16by8_seq_div #(
    parameter int W_Z = 16,
    parameter int W_Y = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W_Z-1:0] z,
    input  logic [W_Y-1:0] y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W_Z-1:0] q,
    output logic [W_Y-1:0] r,
    output logic           div0
);

    localparam int CW = $clog2(W_Z);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [W_Y-1:0] prem, prem_nxt;
    logic [W_Z-1:0] qsr, qsr_nxt;
    logic [W_Y-1:0] y_q, y_nxt;
    logic [W_Z-1:0] q_nxt;
    logic [W_Y-1:0] r_nxt;
    logic           div0_nxt;

    // The trial value carries one extra bit so t (at most 2*y-1) never overflows.
    // The stored remainder is always < y, so its top bit would be constant zero.
    logic [W_Y:0]   t;
    logic [W_Y-1:0] t_sub;
    logic           ge;

    always_comb begin
        t     = {prem, qsr[W_Z-1]};
        ge    = (t >= {1'b0, y_q});
        t_sub = t[W_Y-1:0] - y_q;

        state_nxt = state;
        cnt_nxt   = cnt;
        prem_nxt  = prem;
        qsr_nxt   = qsr;
        y_nxt     = y_q;
        q_nxt     = q;
        r_nxt     = r;
        div0_nxt  = div0;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    y_nxt = y;
                    if (y != '0) begin
                        state_nxt = BUSY;
                        cnt_nxt   = CW'(W_Z - 1);
                        prem_nxt  = '0;
                        qsr_nxt   = z;
                    end else begin
                        state_nxt = DONE;
                        q_nxt     = '1;
                        r_nxt     = z[W_Y-1:0];
                        div0_nxt  = 1'b1;
                    end
                end
            end
            BUSY: begin
                prem_nxt = ge ? t_sub : t[W_Y-1:0];
                qsr_nxt  = {qsr[W_Z-2:0], ge};
                if (cnt == '0) begin
                    state_nxt = DONE;
                    q_nxt     = qsr_nxt;
                    r_nxt     = prem_nxt;
                    div0_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            prem  <= '0;
            qsr   <= '0;
            y_q   <= '0;
            q     <= '0;
            r     <= '0;
            div0  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            prem  <= prem_nxt;
            qsr   <= qsr_nxt;
            y_q   <= y_nxt;
            q     <= q_nxt;
            r     <= r_nxt;
            div0  <= div0_nxt;
        end
    end

endmodule

// File: tb/tb_unsigned_16by8_seq_div.sv
// Bench for unsigned_16by8_seq_div: directed vectors feed a scoreboard queue,
// a negedge monitor pops and compares each handshaked result.
module tb_unsigned_16by8_seq_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] z = '0;
    logic [7:0]  y = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] q;
    logic [7:0]  r;
    logic        div0;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        d;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    unsigned_16by8_seq_div #(.W_Z(16), .W_Y(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .z(z), .y(y),
        .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .r(r), .div0(div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    endtask

    // Monitor: a result is consumed at the next rising edge when both valid and ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {7'd0, q, r, div0}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", {7'd0, q, r, div0}, {7'd0, e.q, e.r, e.d});
            end
        end
    end

    // Drives at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [15:0] zi, input logic [7:0] yi,
                         input logic [15:0] eq, input logic [7:0] er,
                         input logic ed, input bit push);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1; z = zi; y = yi;
        @(posedge clk); #1;
        in_valid = 1'b0; z = $urandom; y = $urandom;
        if (push) exp_q.push_back('{q: eq, r: er, d: ed});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int k;
        logic [15:0] zz;
        logic [7:0]  xx, yy;

        // Reset state, checked while rst is held.
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_q", {16'd0, q}, 32'd0);
        chk("rst_r", {24'd0, r}, 32'd0);
        chk("rst_div0", {31'd0, div0}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1. Basic op and latency.
        issue(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 1'b1);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("latency_y7", k, 32'd16);
        @(posedge clk); #1;
        chk("in_ready_after_done", {31'd0, in_ready}, 32'd1);

        // 2. Boundaries.
        issue(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 1'b1);
        issue(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 1'b1);
        issue(16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 1'b1);
        issue(16'd0, 8'd200, 16'd0, 8'd0, 1'b0, 1'b1);
        drain();

        // 3. Divide by zero.
        issue(16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1, 1'b1);
        chk("latency_div0", {31'd0, out_valid}, 32'd1);
        drain();

        // 4. Backpressure, with in_valid pulses that must be ignored.
        out_ready = 1'b0;
        issue(16'd12345, 8'd100, 16'd123, 8'd45, 1'b0, 1'b1);
        in_valid = 1'b1; z = 16'd1; y = 8'd1;
        @(posedge clk); #1;
        chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; z = 16'd7; y = 8'd2;
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_q", {16'd0, q}, 32'd123);
            chk("hold_r", {24'd0, r}, 32'd45);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (20) @(posedge clk);
        #1;
        chk("no_extra_result", {31'd0, out_valid}, 32'd0);

        // 5. Asynchronous reset mid-operation.
        issue(16'd40000, 8'd3, 16'd0, 8'd0, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_q", {16'd0, q}, 32'd0);
        chk("arst_r", {24'd0, r}, 32'd0);
        chk("arst_div0", {31'd0, div0}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(16'd40000, 8'd3, 16'd13333, 8'd1, 1'b0, 1'b1);
        drain();

        // 6. Random dividends, then exact products that must divide cleanly.
        for (int i = 0; i < 2000; i++) begin
            zz = 16'($urandom_range(0, 65535));
            yy = 8'($urandom_range(1, 255));
            issue(zz, yy, zz / {8'd0, yy}, 8'(zz % {8'd0, yy}), 1'b0, 1'b1);
        end
        for (int i = 0; i < 500; i++) begin
            xx = (i == 0) ? 8'd255 : 8'($urandom_range(0, 255));
            yy = (i == 0) ? 8'd255 : 8'($urandom_range(1, 255));
            zz = {8'd0, xx} * {8'd0, yy};
            issue(zz, yy, {8'd0, xx}, 8'd0, 1'b0, 1'b1);
        end
        drain();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
